// File: rtl/nios_debug_ocimem.sv
// Debug on-chip memory: JTAG and Avalon-MM debug slave sharing one single-port 32-bit RAM.
// JTAG work (pending flags) always wins the port over Avalon requests.
module nios_debug_ocimem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W+1:0] MonAReg,
   output logic              jtag_busy,
   output logic              jtag_overrun,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   input  logic              debugaccess,
   output logic [31:0]       readdata,
   output logic              waitrequest
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, JRD_DATA, ARD_DATA} state_t;

   state_t            state;
   logic [ADDR_W-1:0] mon_word;
   logic [31:0]       wdata;
   logic [31:0]       readdata_q;
   logic              rd_pend;
   logic              wr_pend;

   logic              ram_rd;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [3:0]        ram_be;
   logic [31:0]       ram_q;
   logic [31:0]       mem [DEPTH];

   logic              unused_jdo;
   assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

   assign MonAReg   = {mon_word, 2'b00};
   assign jtag_busy = rd_pend | wr_pend | (state != IDLE);
   // Avalon read data is forwarded straight from the RAM during the data cycle.
   assign readdata  = (state == ARD_DATA) ? ram_q : readdata_q;

   always_comb begin
      waitrequest = 1'b0;
      if (!reset && (read || write)) begin
         case (state)
            IDLE:     waitrequest = rd_pend | wr_pend | read;
            JRD_DATA: waitrequest = 1'b1;
            default:  waitrequest = 1'b0;
         endcase
      end
   end

   // Port arbitration: at most one RAM access per cycle, never on a reset edge.
   always_comb begin
      ram_rd    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = address;
      ram_wdata = writedata;
      ram_be    = 4'b0000;
      if (state == IDLE) begin
         if (wr_pend) begin
            ram_we    = 1'b1;
            ram_addr  = mon_word;
            ram_wdata = wdata;
            ram_be    = 4'b1111;
         end else if (rd_pend) begin
            ram_rd   = 1'b1;
            ram_addr = mon_word;
         end else if (read) begin
            ram_rd = 1'b1;
         end else if (write && debugaccess) begin
            ram_we = 1'b1;
            ram_be = byteenable;
         end
      end
      if (reset) begin
         ram_rd = 1'b0;
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_rd)
         ram_q <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
         if (ram_we && ram_be[i])
            mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
   end

   // Strobe capture only when idle; the FSM never touches pending state then.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         mon_word     <= '0;
         wdata        <= '0;
         readdata_q   <= '0;
         MonDReg      <= '0;
         rd_pend      <= 1'b0;
         wr_pend      <= 1'b0;
         jtag_overrun <= 1'b0;
      end else begin
         if (!jtag_busy) begin
            if (take_action_ocimem_b) begin
               wdata   <= jdo[34:3];
               wr_pend <= 1'b1;
               if (take_action_ocimem_a || take_no_action_ocimem_a)
                  jtag_overrun <= 1'b1;
            end else if (take_action_ocimem_a) begin
               mon_word <= jdo[ADDR_W+9:10];
               rd_pend  <= jdo[35];
               if (take_no_action_ocimem_a)
                  jtag_overrun <= 1'b1;
            end else if (take_no_action_ocimem_a) begin
               mon_word <= mon_word + 1'b1;
               rd_pend  <= 1'b1;
            end
         end else if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b) begin
            jtag_overrun <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (wr_pend) begin
                  mon_word <= mon_word + 1'b1;
                  wr_pend  <= 1'b0;
               end else if (rd_pend) begin
                  rd_pend <= 1'b0;
                  state   <= JRD_DATA;
               end else if (read) begin
                  state <= ARD_DATA;
               end
            end
            JRD_DATA: begin
               MonDReg <= ram_q;
               state   <= IDLE;
            end
            ARD_DATA: begin
               readdata_q <= ram_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios_debug_ocimem.sv
// Randomized self-checking bench for nios_debug_ocimem against a word-level memory model.
module tb_nios_debug_ocimem;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [37:0]   jdo = '0;
   logic          take_action_ocimem_a = 1'b0;
   logic          take_no_action_ocimem_a = 1'b0;
   logic          take_action_ocimem_b = 1'b0;
   logic [31:0]   MonDReg;
   logic [AW+1:0] MonAReg;
   logic          jtag_busy;
   logic          jtag_overrun;
   logic [AW-1:0] address = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = '0;
   logic [3:0]    byteenable = '0;
   logic          debugaccess = 1'b0;
   logic [31:0]   readdata;
   logic          waitrequest;

   int            n_checks = 0;
   int            n_fails = 0;

   logic [31:0]   model_mem [256];
   int            model_a = 0;
   logic [31:0]   model_mondreg = '0;

   nios_debug_ocimem #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .debugaccess(debugaccess),
      .readdata(readdata), .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd);
      logic [37:0] j;
      j = '0;
      j[17:10] = a;
      j[35] = rd;
      return j;
   endfunction

   function automatic logic [37:0] mk_b(input logic [31:0] d);
      logic [37:0] j;
      j = '0;
      j[34:3] = d;
      return j;
   endfunction

   function automatic logic [9:0] model_byte_addr();
      return 10'(model_a * 4);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic sb, input logic sa, input logic sn, input logic [37:0] j);
      take_action_ocimem_b = sb;
      take_action_ocimem_a = sa;
      take_no_action_ocimem_a = sn;
      jdo = j;
      next_cycle();
      take_action_ocimem_b = 1'b0;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (jtag_busy === 1'b1 && n < 20) begin
         next_cycle();
         n++;
      end
      if (n >= 20) begin
         n_fails++;
         $display("[TB] FAIL wait_idle: jtag_busy still %b after %0d cycles, required 0", jtag_busy, n);
      end
   endtask

   task automatic avl_read(input logic [7:0] a, output logic [31:0] d, output int waits);
      address = a;
      read = 1'b1;
      #1;
      waits = 0;
      while (waitrequest === 1'b1 && waits < 20) begin
         next_cycle();
         #1;
         waits++;
      end
      if (waits >= 20) begin
         n_fails++;
         $display("[TB] FAIL avl_read_timeout: waitrequest=%b after %0d cycles, required 0", waitrequest, waits);
      end
      d = readdata;
      next_cycle();
      read = 1'b0;
   endtask

   task automatic avl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic da, output int waits);
      address = a;
      writedata = d;
      byteenable = be;
      debugaccess = da;
      write = 1'b1;
      #1;
      waits = 0;
      while (waitrequest === 1'b1 && waits < 20) begin
         next_cycle();
         #1;
         waits++;
      end
      if (waits >= 20) begin
         n_fails++;
         $display("[TB] FAIL avl_write_timeout: waitrequest=%b after %0d cycles, required 0", waitrequest, waits);
      end
      next_cycle();
      write = 1'b0;
      debugaccess = 1'b0;
      if (da)
         for (int i = 0; i < 4; i++)
            if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic jtag_write(input logic [31:0] d);
      strobe(1'b1, 1'b0, 1'b0, mk_b(d));
      model_mem[model_a] = d;
      model_a = (model_a + 1) % 256;
      wait_idle();
   endtask

   task automatic jtag_load(input logic [7:0] a, input logic rd);
      strobe(1'b0, 1'b1, 1'b0, mk_a(a, rd));
      model_a = a;
      if (rd) model_mondreg = model_mem[model_a];
      wait_idle();
   endtask

   task automatic jtag_next();
      strobe(1'b0, 1'b0, 1'b1, '0);
      model_a = (model_a + 1) % 256;
      model_mondreg = model_mem[model_a];
      wait_idle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      model_a = 0;
      model_mondreg = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      read = 1'b1;
      next_cycle();
      next_cycle();
      #1;
      n_checks += 6;
      if (MonDReg !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_mondreg: got %h want 0", MonDReg); end
      if (MonAReg !== 10'h0) begin n_fails++; $display("[TB] FAIL reset_monareg: got %h want 0", MonAReg); end
      if (jtag_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b want 0", jtag_busy); end
      if (jtag_overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_overrun: got %b want 0", jtag_overrun); end
      if (readdata !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_readdata: got %h want 0", readdata); end
      if (waitrequest !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_waitrequest: got %b want 0", waitrequest); end
      read = 1'b0;
      reset = 1'b0;
      next_cycle();
      model_a = 0;
      model_mondreg = '0;
   endtask

   task automatic test_jtag_write();
      strobe(1'b1, 1'b0, 1'b0, mk_b(32'hDEADBEEF));
      model_mem[0] = 32'hDEADBEEF;
      model_a = 1;
      n_checks++;
      if (jtag_busy !== 1'b1) begin n_fails++; $display("[TB] FAIL jwr_busy_n1: got %b want 1", jtag_busy); end
      next_cycle();
      n_checks += 2;
      if (MonAReg !== 10'h004) begin n_fails++; $display("[TB] FAIL jwr_monareg_n2: got %h want 004", MonAReg); end
      if (jtag_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL jwr_busy_n2: got %b want 0", jtag_busy); end
   endtask

   task automatic test_jtag_read();
      strobe(1'b0, 1'b1, 1'b0, mk_a(8'h00, 1'b1));
      model_a = 0;
      model_mondreg = model_mem[0];
      next_cycle();
      n_checks += 2;
      if (MonDReg !== 32'h0) begin n_fails++; $display("[TB] FAIL jrd_early_mondreg: got %h want 0", MonDReg); end
      if (jtag_busy !== 1'b1) begin n_fails++; $display("[TB] FAIL jrd_busy_n2: got %b want 1", jtag_busy); end
      next_cycle();
      n_checks += 3;
      if (MonDReg !== 32'hDEADBEEF) begin n_fails++; $display("[TB] FAIL jrd_mondreg_n3: got %h want deadbeef", MonDReg); end
      if (jtag_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL jrd_busy_n3: got %b want 0", jtag_busy); end
      if (MonAReg !== 10'h000) begin n_fails++; $display("[TB] FAIL jrd_monareg: got %h want 000", MonAReg); end
   endtask

   task automatic test_wrap();
      jtag_load(8'hFF, 1'b0);
      n_checks++;
      if (MonAReg !== 10'h3FC) begin n_fails++; $display("[TB] FAIL wrap_load: got %h want 3fc", MonAReg); end
      jtag_next();
      n_checks += 2;
      if (MonAReg !== 10'h000) begin n_fails++; $display("[TB] FAIL wrap_next_addr: got %h want 000", MonAReg); end
      if (MonDReg !== model_mondreg) begin n_fails++; $display("[TB] FAIL wrap_next_data: got %h want %h", MonDReg, model_mondreg); end
      jtag_load(8'hFF, 1'b0);
      jtag_write(32'hCAFE0001);
      n_checks++;
      if (MonAReg !== 10'h000) begin n_fails++; $display("[TB] FAIL wrap_write_addr: got %h want 000", MonAReg); end
   endtask

   task automatic test_avalon_contended();
      logic [31:0] d;
      int w;
      avl_write(8'd5, 32'h12345678, 4'hF, 1'b1, w);
      jtag_load(8'h10, 1'b0);
      strobe(1'b1, 1'b0, 1'b0, mk_b(32'h0BADF00D));
      model_mem[8'h10] = 32'h0BADF00D;
      model_a = 8'h11;
      avl_read(8'd5, d, w);
      n_checks += 2;
      if (w !== 2) begin n_fails++; $display("[TB] FAIL avl_contended_waits: got %0d want 2", w); end
      if (d !== 32'h12345678) begin n_fails++; $display("[TB] FAIL avl_contended_data: got %h want 12345678", d); end
      avl_read(8'd5, d, w);
      n_checks += 2;
      if (w !== 1) begin n_fails++; $display("[TB] FAIL avl_free_waits: got %0d want 1", w); end
      if (d !== model_mem[5]) begin n_fails++; $display("[TB] FAIL avl_free_data: got %h want %h", d, model_mem[5]); end
      jtag_load(8'h10, 1'b1);
      n_checks++;
      if (MonDReg !== 32'h0BADF00D) begin n_fails++; $display("[TB] FAIL avl_contended_jwr: got %h want 0badf00d", MonDReg); end
   endtask

   task automatic test_byte_write();
      logic [31:0] d;
      int w;
      avl_write(8'd9, 32'h0, 4'hF, 1'b1, w);
      n_checks++;
      if (w !== 0) begin n_fails++; $display("[TB] FAIL avl_write_waits: got %0d want 0", w); end
      avl_write(8'd9, 32'hAABBCCDD, 4'b0011, 1'b1, w);
      avl_read(8'd9, d, w);
      n_checks++;
      if (d !== 32'h0000CCDD) begin n_fails++; $display("[TB] FAIL byte_write: got %h want 0000ccdd", d); end
      avl_write(8'd9, 32'h11223344, 4'hF, 1'b0, w);
      avl_read(8'd9, d, w);
      n_checks++;
      if (d !== 32'h0000CCDD) begin n_fails++; $display("[TB] FAIL no_debugaccess: got %h want 0000ccdd", d); end
   endtask

   task automatic test_overrun();
      n_checks++;
      if (jtag_overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL overrun_clear: got %b want 0", jtag_overrun); end
      jtag_load(8'h40, 1'b0);
      strobe(1'b1, 1'b0, 1'b0, mk_b(32'h11111111));
      strobe(1'b1, 1'b0, 1'b0, mk_b(32'h22222222));
      model_mem[8'h40] = 32'h11111111;
      model_a = 8'h41;
      wait_idle();
      n_checks += 2;
      if (jtag_overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL overrun_set: got %b want 1", jtag_overrun); end
      if (MonAReg !== model_byte_addr()) begin n_fails++; $display("[TB] FAIL overrun_addr: got %h want %h", MonAReg, model_byte_addr()); end
      jtag_load(8'h40, 1'b1);
      n_checks += 2;
      if (MonDReg !== 32'h11111111) begin n_fails++; $display("[TB] FAIL overrun_data: got %h want 11111111", MonDReg); end
      if (jtag_overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL overrun_sticky: got %b want 1", jtag_overrun); end
   endtask

   task automatic test_priority();
      logic [37:0] j;
      do_reset();
      n_checks++;
      if (jtag_overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_reset_overrun: got %b want 0", jtag_overrun); end
      j = mk_b(32'h5A5A5A5A) | mk_a(8'h77, 1'b1);
      strobe(1'b1, 1'b1, 1'b1, j);
      model_mem[0] = j[34:3];
      model_a = 1;
      wait_idle();
      n_checks += 2;
      if (jtag_overrun !== 1'b1) begin n_fails++; $display("[TB] FAIL prio_overrun: got %b want 1", jtag_overrun); end
      if (MonAReg !== 10'h004) begin n_fails++; $display("[TB] FAIL prio_addr: got %h want 004", MonAReg); end
      jtag_load(8'h00, 1'b1);
      n_checks++;
      if (MonDReg !== model_mondreg) begin n_fails++; $display("[TB] FAIL prio_data: got %h want %h", MonDReg, model_mondreg); end
   endtask

   task automatic test_reset_mid();
      jtag_load(8'h20, 1'b0);
      jtag_write(32'h600DCAFE);
      jtag_load(8'h20, 1'b1);
      strobe(1'b0, 1'b1, 1'b0, mk_a(8'h40, 1'b1));
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      model_a = 0;
      model_mondreg = '0;
      n_checks += 4;
      if (MonDReg !== 32'h0) begin n_fails++; $display("[TB] FAIL rstmid_mondreg: got %h want 0", MonDReg); end
      if (jtag_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_busy: got %b want 0", jtag_busy); end
      if (MonAReg !== 10'h0) begin n_fails++; $display("[TB] FAIL rstmid_addr: got %h want 0", MonAReg); end
      if (jtag_overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_overrun: got %b want 0", jtag_overrun); end
      jtag_load(8'h20, 1'b1);
      n_checks++;
      if (MonDReg !== 32'h600DCAFE) begin n_fails++; $display("[TB] FAIL rstmid_ram_kept: got %h want 600dcafe", MonDReg); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [7:0]  a;
      int          w;
      for (int i = 0; i < 256; i++)
         avl_write(8'(i), $urandom, 4'hF, 1'b1, w);
      for (int k = 0; k < 80; k++) begin
         case ($urandom_range(0, 4))
            0: begin
               jtag_write($urandom);
               n_checks++;
               if (MonAReg !== model_byte_addr()) begin n_fails++; $display("[TB] FAIL rand_jwr_addr: got %h want %h", MonAReg, model_byte_addr()); end
            end
            1: begin
               jtag_load(8'($urandom), 1'b1);
               n_checks++;
               if (MonDReg !== model_mondreg) begin n_fails++; $display("[TB] FAIL rand_jrd_data: got %h want %h", MonDReg, model_mondreg); end
            end
            2: begin
               jtag_next();
               n_checks += 2;
               if (MonAReg !== model_byte_addr()) begin n_fails++; $display("[TB] FAIL rand_jnext_addr: got %h want %h", MonAReg, model_byte_addr()); end
               if (MonDReg !== model_mondreg) begin n_fails++; $display("[TB] FAIL rand_jnext_data: got %h want %h", MonDReg, model_mondreg); end
            end
            3: avl_write(8'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3) != 0, w);
            default: begin
               a = 8'($urandom);
               avl_read(a, d, w);
               n_checks += 2;
               if (d !== model_mem[a]) begin n_fails++; $display("[TB] FAIL rand_avl_data: addr %h got %h want %h", a, d, model_mem[a]); end
               if (w !== 1) begin n_fails++; $display("[TB] FAIL rand_avl_waits: got %0d want 1", w); end
            end
         endcase
      end
      n_checks++;
      if (jtag_overrun !== 1'b0) begin n_fails++; $display("[TB] FAIL rand_overrun: got %b want 0", jtag_overrun); end
   endtask

   initial begin
      test_reset();
      test_jtag_write();
      test_jtag_read();
      test_wrap();
      test_avalon_contended();
      test_byte_write();
      test_overrun();
      test_priority();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
